ov7670_capture_axis: RTL and testbench

- Sits directly downstream of the OV7670 power/reset/XCLK controller.
- Consumes the camera's PCLK/VSYNC/HREF/D[7:0] outputs, pairs bytes into RGB565 pixels and emits them as an AXI4-Stream video stream: tuser = start of frame, tlast = end of line.
- Everything runs in the 100 MHz system clock. Camera inputs are synchronised and PCLK edges are detected in that clock; PCLK = XCLK = 25 MHz, so there are 4 system cycles per PCLK.
- A small FIFO absorbs downstream backpressure. Sticky status bits report overflow and malformed lines.

---
 rtl/ov7670_capture_axis.sv | 209 ++++++++++++++++++++
 tb/tb_ov7670_capture_axis.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture_axis.sv
// rtl/ov7670_capture_axis.sv - OV7670 byte-pair capture to AXI4-Stream RGB565 with output FIFO
module ov7670_capture_axis #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_100mhz,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear_status,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [15:0] frame_count,
  output logic        overflow,
  output logic        line_len_err
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int LW = $clog2(IMG_HEIGHT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [LW-1:0] LINE_MAX = LW'(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DROP} state_t;

  state_t state_q, state_d;

  // Synchroniser stages, packed as {pclk, vsync, href, data[7:0]}
  logic [10:0] sync1, sync2;
  logic        pclk_s3, vsync_s3;
  logic        pclk_s2, vsync_s2, href_s2;
  logic [7:0]  data_s2;
  logic        pclk_rise, vsync_rise, vsync_fall;

  logic          phase_q, sof_q, href_prev_q;
  logic [7:0]    hi_q;
  logic [CW-1:0] col_q;
  logic [LW-1:0] line_q;

  logic wr_en, byte_ev, href_fall, start_frame, end_frame, set_ovf, set_lle;

  logic [17:0]  mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         fifo_empty, fifo_full, pop;
  logic [17:0]  head;

  assign pclk_s2    = sync2[10];
  assign vsync_s2   = sync2[9];
  assign href_s2    = sync2[8];
  assign data_s2    = sync2[7:0];
  assign pclk_rise  = pclk_s2 & ~pclk_s3;
  assign vsync_rise = vsync_s2 & ~vsync_s3;
  assign vsync_fall = ~vsync_s2 & vsync_s3;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = m_axis_tvalid & m_axis_tready;
  assign head       = mem[rd_ptr[AW-1:0]];

  // Outputs are forced to zero while empty so nothing stale is visible
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? 16'h0000 : head[15:0];
  assign m_axis_tlast  = ~fifo_empty & head[16];
  assign m_axis_tuser  = ~fifo_empty & head[17];

  // Two-flop synchronisers for all camera inputs plus a third stage for edge detection
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      pclk_s3  <= 1'b0;
      vsync_s3 <= 1'b0;
    end else begin
      sync1    <= {cam_pclk, cam_vsync, cam_href, cam_data};
      sync2    <= sync1;
      pclk_s3  <= pclk_s2;
      vsync_s3 <= vsync_s2;
    end
  end

  // State register
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-cycle capture events; a full FIFO with a pop in flight still accepts
  always_comb begin
    state_d     = state_q;
    wr_en       = 1'b0;
    byte_ev     = 1'b0;
    href_fall   = 1'b0;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    set_ovf     = 1'b0;
    set_lle     = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_FRAME;
        WAIT_FRAME: begin
          if (vsync_fall) begin
            state_d     = CAPTURE;
            start_frame = 1'b1;
          end
        end
        CAPTURE: begin
          if (vsync_rise) begin
            state_d   = WAIT_FRAME;
            end_frame = 1'b1;
          end else if (pclk_rise && href_s2) begin
            byte_ev = 1'b1;
            if (phase_q && (col_q < COL_MAX) && (line_q < LINE_MAX)) begin
              if (fifo_full && !pop) begin
                set_ovf = 1'b1;
                state_d = DROP;
              end else begin
                wr_en = 1'b1;
              end
            end
          end else if (pclk_rise && href_prev_q) begin
            href_fall = 1'b1;
            set_lle   = (col_q != COL_MAX) || phase_q;
          end
        end
        DROP: begin
          if (vsync_rise) state_d = WAIT_FRAME;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Byte pairing, column/line counters and start-of-frame marker
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= 1'b0;
      hi_q        <= 8'h00;
      col_q       <= '0;
      line_q      <= '0;
      sof_q       <= 1'b0;
      href_prev_q <= 1'b0;
    end else begin
      if (pclk_rise) href_prev_q <= href_s2;
      if (start_frame) begin
        sof_q   <= 1'b1;
        line_q  <= '0;
        col_q   <= '0;
        phase_q <= 1'b0;
      end else if (byte_ev) begin
        if (!phase_q) begin
          hi_q    <= data_s2;
          phase_q <= 1'b1;
        end else begin
          phase_q <= 1'b0;
          if (col_q != COL_MAX) col_q <= col_q + CW'(1);
          if (wr_en) sof_q <= 1'b0;
        end
      end else if (href_fall) begin
        col_q   <= '0;
        phase_q <= 1'b0;
        if (line_q != LINE_MAX) line_q <= line_q + LW'(1);
      end else if (!enable) begin
        phase_q <= 1'b0;
      end
    end
  end

  // Frame counter and sticky status; a set event beats a simultaneous clear
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      frame_count  <= 16'h0000;
      overflow     <= 1'b0;
      line_len_err <= 1'b0;
    end else begin
      if (end_frame) frame_count <= frame_count + 16'd1;
      if (set_ovf)           overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;
      if (set_lle)           line_len_err <= 1'b1;
      else if (clear_status) line_len_err <= 1'b0;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage, entry = {tuser, tlast, pixel}
  always_ff @(posedge clk_100mhz) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {sof_q, (col_q == COL_LAST), hi_q, data_s2};
  end

endmodule

// File: tb/tb_ov7670_capture_axis.sv
// tb/tb_ov7670_capture_axis.sv - self-checking bench for ov7670_capture_axis
module tb_ov7670_capture_axis;
  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk_100mhz = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_status = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [15:0] frame_count;
  logic        overflow;
  logic        line_len_err;

  ov7670_capture_axis #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk_100mhz(clk_100mhz), .reset_n(reset_n), .enable(enable), .clear_status(clear_status),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .frame_count(frame_count),
    .overflow(overflow), .line_len_err(line_len_err)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 0;
  int exp_fc = 0;

  logic [7:0]  fb [4][16];
  int          flen [4];
  int          fnl;
  logic [17:0] exp_q [$];
  logic [17:0] got_q [$];

  typedef struct {
    int nl; int l0; int l1; int l2; int mode; int beats; int tlasts; bit lle;
  } vec_t;
  vec_t tbl [4];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // tready driver: 0 = always ready, 1 = never ready, 2 = random 75 percent
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk_100mhz);
      #2;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'b0;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Beat collector and stall-stability checker
  logic        stall_prev = 1'b0;
  logic [17:0] stall_val = '0;
  always @(negedge clk_100mhz) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_stable", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata},
              {1'b1, stall_val});
      if (m_axis_tvalid && m_axis_tready)
        got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_val  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic pclk_cycle(input logic href, input logic [7:0] d);
    cam_href = href;
    cam_data = d;
    cam_pclk = 1'b0;
    #20;
    cam_pclk = 1'b1;
    #20;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 3; i++) pclk_cycle(1'b0, 8'h00);
    cam_vsync = 1'b0;
    for (int i = 0; i < 3; i++) pclk_cycle(1'b0, 8'h00);
    for (int l = 0; l < fnl; l++) begin
      for (int b = 0; b < flen[l]; b++) pclk_cycle(1'b1, fb[l][b]);
      for (int i = 0; i < 3; i++) pclk_cycle(1'b0, 8'h00);
    end
    cam_vsync = 1'b1;
    for (int i = 0; i < 3; i++) pclk_cycle(1'b0, 8'h00);
  endtask

  task automatic fill_frame(input int nl, input int l0, input int l1, input int l2, input bit rnd);
    int k = 0;
    fnl = nl; flen[0] = l0; flen[1] = l1; flen[2] = l2; flen[3] = 0;
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < 16; b++) begin
        fb[l][b] = rnd ? 8'($urandom) : 8'(17 * (k + 1));
        if (b < flen[l]) k++;
      end
  endtask

  // Reference: each line yields floor(bytes/2) pixels capped at W, only the first H lines
  // are kept, the first kept pixel of the frame carries tuser, pixel W-1 carries tlast.
  task automatic model_frame(output bit lle);
    bit first = 1'b1;
    exp_q.delete();
    lle = 1'b0;
    for (int l = 0; l < fnl; l++) begin
      if (flen[l] != 2 * W) lle = 1'b1;
      if (l < H)
        for (int p = 0; p < flen[l] / 2 && p < W; p++) begin
          exp_q.push_back({first, (p == W - 1), fb[l][2*p], fb[l][2*p+1]});
          first = 1'b0;
        end
    end
  endtask

  task automatic drain_compare(input string tag, output int n, output int nlast);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clk_100mhz);
      t++;
    end
    repeat (16) @(negedge clk_100mhz);
    n = got_q.size();
    nlast = 0;
    check({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < n; i++) begin
      if (got_q[i][16]) nlast++;
      if (i < exp_q.size()) check({tag, "_beat"}, got_q[i], exp_q[i]);
    end
    got_q.delete();
  endtask

  task automatic pulse_clear();
    @(negedge clk_100mhz);
    clear_status = 1'b1;
    @(negedge clk_100mhz);
    clear_status = 1'b0;
  endtask

  initial begin
    bit lle_m;
    int n, nl;

    tbl[0] = '{2, 8, 8, 0, 0, 8, 2, 1'b0};
    tbl[1] = '{2, 6, 9, 0, 0, 7, 1, 1'b1};
    tbl[2] = '{3, 8, 8, 8, 0, 8, 2, 1'b0};
    tbl[3] = '{2, 8, 8, 0, 2, 8, 2, 1'b0};

    repeat (3) @(negedge clk_100mhz);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser_tlast", {m_axis_tuser, m_axis_tlast}, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_status", {overflow, line_len_err}, 0);
    reset_n = 1'b1;
    @(negedge clk_100mhz);
    enable = 1'b1;
    repeat (2) @(negedge clk_100mhz);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      fill_frame(tbl[v].nl, tbl[v].l0, tbl[v].l1, tbl[v].l2, 1'b0);
      rdy_mode = tbl[v].mode;
      model_frame(lle_m);
      send_frame();
      exp_fc++;
      drain_compare("tbl", n, nl);
      check("tbl_beats", n, tbl[v].beats);
      check("tbl_tlasts", nl, tbl[v].tlasts);
      check("tbl_lle", line_len_err, tbl[v].lle);
      check("tbl_overflow", overflow, 0);
      check("tbl_frame_count", frame_count, exp_fc);
      pulse_clear();
      check("tbl_clear", {overflow, line_len_err}, 0);
    end

    // Backpressure: stall the first four pixels, then release
    fill_frame(2, 8, 8, 0, 1'b0);
    model_frame(lle_m);
    rdy_mode = 1;
    fork
      send_frame();
      begin
        #640;
        check("bp_held_valid", m_axis_tvalid, 1);
        check("bp_none_popped", got_q.size(), 0);
        #10;
        rdy_mode = 0;
      end
    join
    exp_fc++;
    drain_compare("bp", n, nl);
    check("bp_overflow", overflow, 0);
    check("bp_frame_count", frame_count, exp_fc);

    // Overflow: no ready for a whole frame
    fill_frame(2, 8, 8, 0, 1'b0);
    model_frame(lle_m);
    rdy_mode = 1;
    send_frame();
    check("ovf_none_popped", got_q.size(), 0);
    check("ovf_flag", overflow, 1);
    check("ovf_frame_count", frame_count, exp_fc);
    while (exp_q.size() > D) void'(exp_q.pop_back());
    rdy_mode = 0;
    drain_compare("ovf", n, nl);
    fill_frame(2, 8, 8, 0, 1'b1);
    model_frame(lle_m);
    send_frame();
    exp_fc++;
    drain_compare("ovf_next", n, nl);
    check("ovf_next_frame_count", frame_count, exp_fc);
    check("ovf_sticky", overflow, 1);
    pulse_clear();
    check("ovf_clear", overflow, 0);

    // Enable dropped after pixel 1 of line 0, restored during line 1
    fill_frame(2, 8, 8, 0, 1'b0);
    model_frame(lle_m);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    fork
      send_frame();
      begin
        #440;
        enable = 1'b0;
        #260;
        enable = 1'b1;
      end
    join
    drain_compare("en", n, nl);
    check("en_frame_count", frame_count, exp_fc);
    check("en_status", {overflow, line_len_err}, 0);
    fill_frame(2, 8, 8, 0, 1'b1);
    model_frame(lle_m);
    send_frame();
    exp_fc++;
    drain_compare("en_next", n, nl);
    check("en_next_frame_count", frame_count, exp_fc);

    // Randomized frames against the reference model
    for (int r = 0; r < 6; r++) begin
      fill_frame($urandom_range(1, 3), $urandom_range(1, 2*W+1), $urandom_range(1, 2*W+1),
                 $urandom_range(1, 2*W+1), 1'b1);
      rdy_mode = 2;
      model_frame(lle_m);
      send_frame();
      exp_fc++;
      drain_compare("rnd", n, nl);
      check("rnd_lle", line_len_err, lle_m);
      check("rnd_overflow", overflow, 0);
      check("rnd_frame_count", frame_count, exp_fc);
      pulse_clear();
    end
    rdy_mode = 0;

    // Asynchronous reset mid-frame with data held in the FIFO
    fill_frame(2, 8, 8, 0, 1'b0);
    rdy_mode = 1;
    fork
      send_frame();
      begin
        #503;
        reset_n = 1'b0;
        #1;
        check("arst_tvalid", m_axis_tvalid, 0);
        check("arst_frame_count", frame_count, 0);
        check("arst_status", {overflow, line_len_err}, 0);
        check("arst_tdata", m_axis_tdata, 0);
      end
    join
    got_q.delete();
    rdy_mode = 0;
    exp_fc = 0;
    @(negedge clk_100mhz);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_100mhz);
    check("arst_after_tvalid", m_axis_tvalid, 0);

    // frame_count wrap
    force dut.frame_count = 16'hFFFF;
    @(negedge clk_100mhz);
    release dut.frame_count;
    @(negedge clk_100mhz);
    check("wrap_preload", frame_count, 16'hFFFF);
    fill_frame(2, 8, 8, 0, 1'b1);
    model_frame(lle_m);
    send_frame();
    drain_compare("wrap", n, nl);
    check("wrap_frame_count", frame_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
